// File: rtl/pkt_proto_pkg.sv
// ---------------------------------------------------------------------------
// pkt_proto_pkg
// Shared packet-protocol definitions for the packet write arbiter.
//   DATA_LINE_WIDTH    : payload bits per flit
//   CONTROL_LINE_WIDTH : control bits per flit (bit 0 of control is EOP)
//   PKT_W              : total flit width
//   EOP_BIT            : flit bit index of the end-of-packet flag
//   arb_state_e        : arbiter FSM state encoding
//   ptr_width()        : width of a round-robin pointer for n requesters
// ---------------------------------------------------------------------------
package pkt_proto_pkg;

    localparam int DATA_LINE_WIDTH    = 64;
    localparam int CONTROL_LINE_WIDTH = 6;
    localparam int PKT_W              = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
    localparam int EOP_BIT            = DATA_LINE_WIDTH;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // A single requester still needs a 1-bit pointer so the port is legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority search. Starting at rr_ptr and moving
// upward modulo NUM_REQ, the first asserted request bit is returned one-hot.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle
//   pick   : one-hot selected requester, all zero when req is all zero
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = pkt_proto_pkg::ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick
);

    always_comb begin
        int idx;
        pick = '0;
        idx  = 0;
        // Offsets are walked from farthest to nearest, so the requester
        // closest to rr_ptr is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == idx && req[j]) begin
                    pick    = '0;
                    pick[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pkt_write_arbiter.sv
// ---------------------------------------------------------------------------
// pkt_write_arbiter
// Shares one packet-FIFO write port among NUM_REQ packet requesters. A
// requester is picked round-robin in IDLE and holds the port (LOCKED) until
// its EOP flit is written; every packet is followed by one IDLE cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_req_valid         : per-requester flit valid
//   i_req_packet        : flattened flits, requester k at [k*PKT_W +: PKT_W]
//   o_req_ready         : per-requester flit accepted (with valid)
//   i_fifo_full         : FIFO full flag
//   o_fifo_write_en     : FIFO write enable
//   o_fifo_write_packet : FIFO write data (zero when idle)
//   o_grant             : registered one-hot grant, zero when idle
//   o_busy              : high while a packet owns the port
//   o_pkt_count         : completed packets, wrapping 16-bit count
// ---------------------------------------------------------------------------
module pkt_write_arbiter #(
    parameter int  NUM_REQ            = 4,
    parameter int  DATA_LINE_WIDTH    = pkt_proto_pkg::DATA_LINE_WIDTH,
    parameter int  CONTROL_LINE_WIDTH = pkt_proto_pkg::CONTROL_LINE_WIDTH,
    localparam int PKT_W              = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] i_req_packet,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_write_en,
    output logic [PKT_W-1:0]         o_fifo_write_packet,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_busy,
    output logic [15:0]              o_pkt_count
);

    import pkt_proto_pkg::*;

    localparam int EOP_IDX = DATA_LINE_WIDTH;
    localparam int PTR_W   = ptr_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic [NUM_REQ-1:0] pick;
    logic [PKT_W-1:0]   granted_flit;
    logic               locked;
    logic               granted_valid;
    logic               write_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (i_req_valid),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    // AND-OR mux on the one-hot grant; yields zero when nothing is granted.
    always_comb begin
        granted_flit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                granted_flit |= i_req_packet[k*PKT_W +: PKT_W];
            end
        end
    end

    assign locked        = (state_q == ST_LOCKED);
    assign granted_valid = |(i_req_valid & grant_q);
    assign write_en      = locked && granted_valid && !i_fifo_full;

    assign o_req_ready         = (locked && !i_fifo_full) ? grant_q : '0;
    assign o_fifo_write_en     = write_en;
    assign o_fifo_write_packet = locked ? granted_flit : '0;
    assign o_grant             = grant_q;
    assign o_busy              = locked;
    assign o_pkt_count         = pkt_count_q;

    always_comb begin
        // NOTE: every signal gets its hold value before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    state_d = ST_LOCKED;
                    grant_d = pick;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (pick[k]) begin
                            rr_ptr_d = PTR_W'((k + 1) % NUM_REQ);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Stalls (full or valid low) simply hold the grant.
                if (write_en && granted_flit[EOP_IDX]) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let all registers sample the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_pkt_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pkt_write_arbiter
// Directed bench for pkt_write_arbiter. The stimulus thread pushes each
// expected FIFO write (flit and owning grant) into a queue; a monitor pops
// and compares whenever the DUT asserts o_fifo_write_en. Cycle-level
// expectations (grant, ready, busy, count) are checked by the stimulus.
// ---------------------------------------------------------------------------
module tb_pkt_write_arbiter;

    import pkt_proto_pkg::*;

    localparam int N  = 4;
    localparam int PW = PKT_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    valid;
    logic [PW-1:0]   flit [N];
    logic [N*PW-1:0] req_packet;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_we;
    logic [PW-1:0]   fifo_pkt;
    logic [N-1:0]    grant;
    logic            busy;
    logic [15:0]     pkt_count;

    typedef struct {
        logic [PW-1:0] pkt;
        logic [N-1:0]  grant;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign req_packet[g*PW +: PW] = flit[g];
    end

    pkt_write_arbiter #(
        .NUM_REQ            (N),
        .DATA_LINE_WIDTH    (DATA_LINE_WIDTH),
        .CONTROL_LINE_WIDTH (CONTROL_LINE_WIDTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req_valid         (valid),
        .i_req_packet        (req_packet),
        .o_req_ready         (req_ready),
        .i_fifo_full         (fifo_full),
        .o_fifo_write_en     (fifo_we),
        .o_fifo_write_packet (fifo_pkt),
        .o_grant             (grant),
        .o_busy              (busy),
        .o_pkt_count         (pkt_count)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flit tagged with requester and sequence number; upper control bits
    // carry a requester tag so the whole flit width is exercised.
    function automatic logic [PW-1:0] make_flit(input int req, input int seq, input bit eop);
        logic [PW-1:0] f;
        f = '0;
        f[DATA_LINE_WIDTH-1:0] = {8'hA5, 8'(req), 16'h5A00, 32'(seq)};
        f[PW-1:EOP_BIT+1]      = 5'(req + 1);
        f[EOP_BIT]             = eop;
        return f;
    endfunction

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input bit v, input int seq, input bit eop);
        valid[k] = v;
        flit[k]  = make_flit(k, seq, eop);
    endtask

    task automatic expect_write(input int k, input int seq, input bit eop);
        exp_t e;
        e.pkt   = make_flit(k, seq, eop);
        e.grant = oh(k);
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        check({name, "_grant"}, PW'(grant), PW'(0));
        check({name, "_we"}, PW'(fifo_we), PW'(0));
        check({name, "_busy"}, PW'(busy), PW'(0));
    endtask

    task automatic check_locked(input string name, input int k, input bit exp_we);
        check({name, "_grant"}, PW'(grant), PW'(oh(k)));
        check({name, "_we"}, PW'(fifo_we), PW'(exp_we));
        check({name, "_busy"}, PW'(busy), PW'(1));
    endtask

    // Scoreboard monitor: every write must match the oldest expectation.
    always @(negedge clk) begin
        if (fifo_we) begin
            check("wr_not_full", PW'(fifo_full), PW'(0));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got write %h expected no write at %0t", fifo_pkt, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_pkt", fifo_pkt, e.pkt);
                check("wr_grant", PW'(grant), PW'(e.grant));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n     = 1'b0;
        valid     = '0;
        fifo_full = 1'b0;
        for (int k = 0; k < N; k++) begin
            flit[k] = '0;
        end

        // Reset state
        #12;
        check_idle("rst");
        check("rst_ready", PW'(req_ready), PW'(0));
        check("rst_pkt", fifo_pkt, PW'(0));
        check("rst_count", PW'(pkt_count), PW'(0));
        tick();
        rst_n = 1'b1;

        // All four valid, single-flit packets: grants 0,1,2,3,0
        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b1, 0, 1'b1);
        end
        for (int p = 0; p < 5; p++) begin
            expect_write(p % N, 0, 1'b1);
        end
        for (int p = 0; p < 5; p++) begin
            sample();
            check_idle("rr_idle");
            tick();
            sample();
            check_locked("rr_lock", p % N, 1'b1);
            check("rr_ready", PW'(req_ready), PW'(oh(p % N)));
            tick();
        end
        valid = '0;
        sample();
        check("rr_count", PW'(pkt_count), PW'(5));

        // 3-flit packet from requester 2 while requester 0 waits
        tick();
        set_req(0, 1'b1, 0, 1'b1);
        set_req(2, 1'b1, 0, 1'b0);
        expect_write(2, 0, 1'b0);
        expect_write(2, 1, 1'b0);
        expect_write(2, 2, 1'b1);
        expect_write(0, 0, 1'b1);
        sample();
        check_idle("mf_idle0");
        tick();
        sample();
        check_locked("mf_f0", 2, 1'b1);
        tick();
        set_req(2, 1'b1, 1, 1'b0);
        sample();
        check_locked("mf_f1", 2, 1'b1);
        tick();
        set_req(2, 1'b1, 2, 1'b1);
        sample();
        check_locked("mf_f2", 2, 1'b1);
        tick();
        valid[2] = 1'b0;
        sample();
        check_idle("mf_gap");
        tick();
        sample();
        check_locked("mf_next", 0, 1'b1);
        tick();
        valid[0] = 1'b0;
        sample();
        check("mf_count", PW'(pkt_count), PW'(7));

        // FIFO full for 4 cycles mid-packet
        tick();
        set_req(1, 1'b1, 0, 1'b0);
        expect_write(1, 0, 1'b0);
        expect_write(1, 1, 1'b0);
        expect_write(1, 2, 1'b1);
        sample();
        check_idle("full_idle");
        tick();
        sample();
        check_locked("full_f0", 1, 1'b1);
        tick();
        set_req(1, 1'b1, 1, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check_locked("full_stall", 1, 1'b0);
            check("full_ready", PW'(req_ready), PW'(0));
            tick();
        end
        fifo_full = 1'b0;
        sample();
        check_locked("full_release", 1, 1'b1);
        check("full_rel_ready", PW'(req_ready), PW'(oh(1)));
        tick();
        set_req(1, 1'b1, 2, 1'b1);
        sample();
        check_locked("full_f2", 1, 1'b1);
        tick();
        valid[1] = 1'b0;
        sample();
        check("full_count", PW'(pkt_count), PW'(8));

        // Granted requester drops valid while requester 3 is waiting
        tick();
        set_req(2, 1'b1, 0, 1'b0);
        set_req(3, 1'b1, 0, 1'b1);
        expect_write(2, 0, 1'b0);
        expect_write(2, 1, 1'b1);
        expect_write(3, 0, 1'b1);
        sample();
        check_idle("vd_idle");
        tick();
        sample();
        check_locked("vd_f0", 2, 1'b1);
        tick();
        valid[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check_locked("vd_hold", 2, 1'b0);
            check("vd_ready", PW'(req_ready), PW'(oh(2)));
            tick();
        end
        set_req(2, 1'b1, 1, 1'b1);
        sample();
        check_locked("vd_f1", 2, 1'b1);
        tick();
        valid[2] = 1'b0;
        sample();
        check_idle("vd_gap");
        tick();
        sample();
        check_locked("vd_other", 3, 1'b1);
        tick();
        valid[3] = 1'b0;
        sample();
        check("vd_count", PW'(pkt_count), PW'(10));

        // Reset asserted during the second flit of a packet
        tick();
        set_req(1, 1'b1, 0, 1'b0);
        expect_write(1, 0, 1'b0);
        sample();
        check_idle("mr_idle");
        tick();
        sample();
        check_locked("mr_f0", 1, 1'b1);
        tick();
        set_req(1, 1'b1, 1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_grant", PW'(grant), PW'(0));
        check("mr_busy", PW'(busy), PW'(0));
        check("mr_we", PW'(fifo_we), PW'(0));
        check("mr_ready", PW'(req_ready), PW'(0));
        check("mr_pkt", fifo_pkt, PW'(0));
        check("mr_count", PW'(pkt_count), PW'(0));
        valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_idle("mr_after");
            check("mr_after_count", PW'(pkt_count), PW'(0));
            tick();
        end

        // Counter wrap: load 0xFFFE, then two packets (pointer restarts at 0)
        sample();
        force dut.pkt_count_d = 16'hFFFE;
        sample();
        release dut.pkt_count_d;
        check("wrap_load", PW'(pkt_count), PW'(16'hFFFE));
        tick();
        set_req(0, 1'b1, 0, 1'b1);
        set_req(1, 1'b1, 0, 1'b1);
        expect_write(0, 0, 1'b1);
        expect_write(1, 0, 1'b1);
        sample();
        check_idle("wrap_idle0");
        tick();
        sample();
        check_locked("wrap_p0", 0, 1'b1);
        tick();
        sample();
        check("wrap_ffff", PW'(pkt_count), PW'(16'hFFFF));
        tick();
        sample();
        check_locked("wrap_p1", 1, 1'b1);
        tick();
        valid = '0;
        sample();
        check("wrap_zero", PW'(pkt_count), PW'(0));
        check_idle("wrap_end");

        repeat (3) sample();
        check("sb_empty", PW'(exp_q.size()), PW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
